// File: rtl/lotr_pkg.sv
// Shared LOTR ring types: opcodes, the ring packet bundle and the tile-ID field position.
package lotr_pkg;

    localparam int CORE_ID_MSB = 31;
    localparam int CORE_ID_LSB = 24;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_ring_pkt;

endpackage

// File: rtl/ring_stub_rsp_fifo.sv
// Synchronous FIFO of ring packets holding responses generated by the stub.
// Pointers carry one extra wrap bit so full and empty stay distinct at DEPTH entries.
module ring_stub_rsp_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  t_ring_pkt i_push_pkt,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output t_ring_pkt o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    t_ring_pkt   r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_pkt;
    end

endmodule

// File: rtl/ring_stub_tile.sv
// Ring stop standing in for an absent tile: forwards traffic through a PIPE_DEPTH pipeline and
// answers requests to STUB_ID. Define RING_STUB_CNT_EN to add hit/response counters.
module ring_stub_tile
    import lotr_pkg::*;
#(
    parameter int          PIPE_DEPTH      = 2,
    parameter int          RSP_FIFO_DEPTH  = 4,
    parameter logic [7:0]  STUB_ID         = 8'd2,
    parameter logic [31:0] DEFAULT_RD_DATA = 32'hDEAD_BEEF
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        RingReqInValidQ500H,
    input  logic [9:0]  RingReqInRequestorQ500H,
    input  t_opcode     RingReqInOpcodeQ500H,
    input  logic [31:0] RingReqInAddressQ500H,
    input  logic [31:0] RingReqInDataQ500H,
    input  logic        RingRspInValidQ500H,
    input  logic [9:0]  RingRspInRequestorQ500H,
    input  t_opcode     RingRspInOpcodeQ500H,
    input  logic [31:0] RingRspInAddressQ500H,
    input  logic [31:0] RingRspInDataQ500H,
    output logic        RingReqOutValidQ502H,
    output logic [9:0]  RingReqOutRequestorQ502H,
    output t_opcode     RingReqOutOpcodeQ502H,
    output logic [31:0] RingReqOutAddressQ502H,
    output logic [31:0] RingReqOutDataQ502H,
    output logic        RingRspOutValidQ502H,
    output logic [9:0]  RingRspOutRequestorQ502H,
    output t_opcode     RingRspOutOpcodeQ502H,
    output logic [31:0] RingRspOutAddressQ502H,
    output logic [31:0] RingRspOutDataQ502H
`ifdef RING_STUB_CNT_EN
    ,
    output logic [15:0] StubReqCntQnnnH,
    output logic [15:0] StubRspCntQnnnH
`endif
);
    t_ring_pkt w_req_in;
    t_ring_pkt w_rsp_in;
    t_ring_pkt w_gen_rsp;
    t_ring_pkt w_fifo_head;
    t_ring_pkt w_rsp_stage0;
    logic      w_hit;
    logic      w_push;
    logic      w_pop;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_req_vld0;
    logic      w_rsp_vld0;

    logic [PIPE_DEPTH-1:0] r_req_vld;
    logic [PIPE_DEPTH-1:0] r_rsp_vld;
    t_ring_pkt             r_req_pkt [PIPE_DEPTH];
    t_ring_pkt             r_rsp_pkt [PIPE_DEPTH];

    assign w_req_in = '{requestor: RingReqInRequestorQ500H, opcode: RingReqInOpcodeQ500H,
                        address: RingReqInAddressQ500H, data: RingReqInDataQ500H};
    assign w_rsp_in = '{requestor: RingRspInRequestorQ500H, opcode: RingRspInOpcodeQ500H,
                        address: RingRspInAddressQ500H, data: RingRspInDataQ500H};

    // A hit is only consumed when there is room; otherwise it keeps circulating and retries.
    assign w_hit      = RingReqInValidQ500H &&
                        (RingReqInAddressQ500H[CORE_ID_MSB:CORE_ID_LSB] == STUB_ID);
    assign w_push     = w_hit && !w_fifo_full;
    assign w_pop      = !RingRspInValidQ500H && !w_fifo_empty;
    assign w_req_vld0 = RingReqInValidQ500H && !w_push;

    always_comb begin
        w_gen_rsp           = '0;
        w_gen_rsp.requestor = RingReqInRequestorQ500H;
        w_gen_rsp.address   = RingReqInAddressQ500H;
        case (RingReqInOpcodeQ500H)
            RD: begin
                w_gen_rsp.opcode = RD_RSP;
                w_gen_rsp.data   = DEFAULT_RD_DATA;
            end
            WR: begin
                w_gen_rsp.opcode = WR_RSP;
                w_gen_rsp.data   = RingReqInDataQ500H;
            end
            default: begin
                w_gen_rsp.opcode = WR_RSP;
                w_gen_rsp.data   = '0;
            end
        endcase
    end

    // Ring responses always win the first stage; generated ones only fill idle slots.
    always_comb begin
        w_rsp_vld0   = RingRspInValidQ500H || w_pop;
        w_rsp_stage0 = '0;
        if (RingRspInValidQ500H) w_rsp_stage0 = w_rsp_in;
        else if (w_pop)          w_rsp_stage0 = w_fifo_head;
    end

    ring_stub_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_clk      (QClk),
        .i_rst      (RstQnnnH),
        .i_push     (w_push),
        .i_push_pkt (w_gen_rsp),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head     (w_fifo_head)
    );

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            r_req_vld <= '0;
            r_rsp_vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_req_pkt[i] <= '0;
                r_rsp_pkt[i] <= '0;
            end
        end else begin
            r_req_vld[0] <= w_req_vld0;
            r_req_pkt[0] <= w_req_in;
            r_rsp_vld[0] <= w_rsp_vld0;
            r_rsp_pkt[0] <= w_rsp_stage0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_req_vld[i] <= r_req_vld[i-1];
                r_req_pkt[i] <= r_req_pkt[i-1];
                r_rsp_vld[i] <= r_rsp_vld[i-1];
                r_rsp_pkt[i] <= r_rsp_pkt[i-1];
            end
        end
    end

    assign RingReqOutValidQ502H     = r_req_vld[PIPE_DEPTH-1];
    assign RingReqOutRequestorQ502H = r_req_pkt[PIPE_DEPTH-1].requestor;
    assign RingReqOutOpcodeQ502H    = r_req_pkt[PIPE_DEPTH-1].opcode;
    assign RingReqOutAddressQ502H   = r_req_pkt[PIPE_DEPTH-1].address;
    assign RingReqOutDataQ502H      = r_req_pkt[PIPE_DEPTH-1].data;
    assign RingRspOutValidQ502H     = r_rsp_vld[PIPE_DEPTH-1];
    assign RingRspOutRequestorQ502H = r_rsp_pkt[PIPE_DEPTH-1].requestor;
    assign RingRspOutOpcodeQ502H    = r_rsp_pkt[PIPE_DEPTH-1].opcode;
    assign RingRspOutAddressQ502H   = r_rsp_pkt[PIPE_DEPTH-1].address;
    assign RingRspOutDataQ502H      = r_rsp_pkt[PIPE_DEPTH-1].data;

`ifdef RING_STUB_CNT_EN
    logic [15:0] r_req_cnt;
    logic [15:0] r_rsp_cnt;

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_push && (r_req_cnt != 16'hFFFF)) r_req_cnt <= r_req_cnt + 16'd1;
            if (w_pop && (r_rsp_cnt != 16'hFFFF))  r_rsp_cnt <= r_rsp_cnt + 16'd1;
        end
    end

    assign StubReqCntQnnnH = r_req_cnt;
    assign StubRspCntQnnnH = r_rsp_cnt;
`endif

endmodule

// File: tb/tb_ring_stub_tile.sv
// Directed scoreboard bench for ring_stub_tile (PIPE_DEPTH=2, FIFO depth 4, STUB_ID=2).
module tb_ring_stub_tile;
    import lotr_pkg::*;

    localparam int PD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic      req_v, rsp_v;
    t_ring_pkt req_p, rsp_p;

    logic        ro_v, so_v;
    logic [9:0]  ro_r, so_r;
    t_opcode     ro_o, so_o;
    logic [31:0] ro_a, so_a, ro_d, so_d;
    t_ring_pkt   ro_p, so_p;
    assign ro_p = {ro_r, ro_o, ro_a, ro_d};
    assign so_p = {so_r, so_o, so_a, so_d};

`ifdef RING_STUB_CNT_EN
    logic [15:0] req_cnt, rsp_cnt;
`endif

    ring_stub_tile dut (
        .QClk                     (clk),
        .RstQnnnH                 (rst),
        .RingReqInValidQ500H      (req_v),
        .RingReqInRequestorQ500H  (req_p.requestor),
        .RingReqInOpcodeQ500H     (req_p.opcode),
        .RingReqInAddressQ500H    (req_p.address),
        .RingReqInDataQ500H       (req_p.data),
        .RingRspInValidQ500H      (rsp_v),
        .RingRspInRequestorQ500H  (rsp_p.requestor),
        .RingRspInOpcodeQ500H     (rsp_p.opcode),
        .RingRspInAddressQ500H    (rsp_p.address),
        .RingRspInDataQ500H       (rsp_p.data),
        .RingReqOutValidQ502H     (ro_v),
        .RingReqOutRequestorQ502H (ro_r),
        .RingReqOutOpcodeQ502H    (ro_o),
        .RingReqOutAddressQ502H   (ro_a),
        .RingReqOutDataQ502H      (ro_d),
        .RingRspOutValidQ502H     (so_v),
        .RingRspOutRequestorQ502H (so_r),
        .RingRspOutOpcodeQ502H    (so_o),
        .RingRspOutAddressQ502H   (so_a),
        .RingRspOutDataQ502H      (so_d)
`ifdef RING_STUB_CNT_EN
        ,
        .StubReqCntQnnnH          (req_cnt),
        .StubRspCntQnnnH          (rsp_cnt)
`endif
    );

    typedef struct {
        t_ring_pkt p;
        int        c;
    } t_exp;

    t_exp q_req[$];
    t_exp q_rsp[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   sb_on = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic t_ring_pkt mk(input logic [9:0] r, input t_opcode o,
                                     input logic [31:0] a, input logic [31:0] d);
        t_ring_pkt p;
        p.requestor = r;
        p.opcode    = o;
        p.address   = a;
        p.data      = d;
        return p;
    endfunction

    task automatic exp_req(input t_ring_pkt p, input int c);
        t_exp e;
        e.p = p;
        e.c = c;
        q_req.push_back(e);
    endtask

    task automatic exp_rsp(input t_ring_pkt p, input int c);
        t_exp e;
        e.p = p;
        e.c = c;
        q_rsp.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        @(negedge clk);
        chk({nm, "_req_v"}, 128'(ro_v), 128'd0);
        chk({nm, "_req_pkt"}, 128'(ro_p), 128'd0);
        chk({nm, "_rsp_v"}, 128'(so_v), 128'd0);
        chk({nm, "_rsp_pkt"}, 128'(so_p), 128'd0);
`ifdef RING_STUB_CNT_EN
        chk({nm, "_req_cnt"}, 128'(req_cnt), 128'd0);
        chk({nm, "_rsp_cnt"}, 128'(rsp_cnt), 128'd0);
`endif
    endtask

    // Monitor: every valid output must match the oldest expectation, payload and cycle.
    always @(negedge clk) begin
        t_exp e;
        if (sb_on && !rst) begin
            if (ro_v) begin
                if (q_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_out_unexpected actual=%0h required=none (cyc %0d)", ro_p, cyc);
                end else begin
                    e = q_req.pop_front();
                    chk("req_out_pkt", 128'(ro_p), 128'(e.p));
                    chk("req_out_cyc", 128'(cyc), 128'(e.c));
                end
            end
            if (so_v) begin
                if (q_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_out_unexpected actual=%0h required=none (cyc %0d)", so_p, cyc);
                end else begin
                    e = q_rsp.pop_front();
                    chk("rsp_out_pkt", 128'(so_p), 128'(e.p));
                    chk("rsp_out_cyc", 128'(cyc), 128'(e.c));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Hand-computed responses for test 4: RD, WR, RD_RSP(other), WR.
    t_opcode     t4_op  [4] = '{RD, WR, RD_RSP, WR};
    t_opcode     t4_rop [4] = '{RD_RSP, WR_RSP, WR_RSP, WR_RSP};
    logic [31:0] t4_rd  [4] = '{32'hDEAD_BEEF, 32'h0000_0101, 32'h0000_0000, 32'h0000_0103};

    initial begin
        int k;
        req_v = 1'b0;
        rsp_v = 1'b0;
        req_p = '0;
        rsp_p = '0;
        repeat (2) @(posedge clk);
        chk_all_zero("reset");
        step();
        rst = 1'b0;

        // 1: non-hit passes unchanged after PD cycles
        step();
        req_v = 1'b1;
        req_p = mk(10'h5, RD, 32'h0100_0010, 32'h0000_0000);
        exp_req(req_p, cyc + PD);
        step();
        req_v = 1'b0;
        repeat (6) step();

        // 2: read hit on idle response channel
        req_v = 1'b1;
        req_p = mk(10'h3, RD, 32'h0200_0010, 32'hAAAA_5555);
        exp_rsp(mk(10'h3, RD_RSP, 32'h0200_0010, 32'hDEAD_BEEF), cyc + PD + 1);
        step();
        req_v = 1'b0;
        repeat (6) step();

        // 3: write hit while 3 incoming responses occupy the channel
        k = cyc;
        req_v = 1'b1;
        req_p = mk(10'h7, WR, 32'h0200_0004, 32'h0000_1234);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            if (j == 1) req_v = 1'b0;
            rsp_v = 1'b1;
            rsp_p = mk(10'h20 + 10'(j), RD_RSP, 32'h0300_0000 + j, 32'h5000 + j);
            exp_rsp(rsp_p, cyc + PD);
        end
        exp_rsp(mk(10'h7, WR_RSP, 32'h0200_0004, 32'h0000_1234), k + 5);
        step();
        rsp_v = 1'b0;
        repeat (8) step();

        // 4: five hits against a busy channel; the fifth finds the FIFO full
        k = cyc;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) step();
            if (j < 4) begin
                req_v = 1'b1;
                req_p = mk(10'h10 + 10'(j), t4_op[j], 32'h0200_0100 + 4 * j, 32'h100 + j);
            end else if (j == 4) begin
                req_v = 1'b1;
                req_p = mk(10'h14, RD, 32'h0200_0110, 32'h0000_0104);
                exp_req(req_p, cyc + PD);
            end else begin
                req_v = 1'b0;
            end
            rsp_v = 1'b1;
            rsp_p = mk(10'h40 + 10'(j), WR_RSP, 32'h0400_0000 + j, 32'h6000 + j);
            exp_rsp(rsp_p, cyc + PD);
        end
        for (int i = 0; i < 4; i++)
            exp_rsp(mk(10'h10 + 10'(i), t4_rop[i], 32'h0200_0100 + 4 * i, t4_rd[i]), k + 8 + i);
        step();
        rsp_v = 1'b0;
        repeat (14) step();

        // 5: reset with two pending responses and traffic in flight
        req_v = 1'b1;
        req_p = mk(10'h50, RD, 32'h0200_0020, 32'h0);
        rsp_v = 1'b1;
        rsp_p = mk(10'h60, RD_RSP, 32'h0600_0000, 32'h1);
        step();
        req_p = mk(10'h51, WR, 32'h0200_0024, 32'h2);
        rsp_p = mk(10'h61, RD_RSP, 32'h0600_0001, 32'h3);
        step();
        req_p = mk(10'h52, WR, 32'h0100_0000, 32'h4);
        rsp_p = mk(10'h62, RD_RSP, 32'h0600_0002, 32'h5);
        rst = 1'b1;
        chk_all_zero("mid_reset");
        req_v = 1'b0;
        rsp_v = 1'b0;
        step();
        rst = 1'b0;
        repeat (10) step();
        req_v = 1'b1;
        req_p = mk(10'h77, WR, 32'h0700_0000, 32'h0000_00AA);
        exp_req(req_p, cyc + PD);
        step();
        req_v = 1'b0;
        repeat (6) step();

`ifdef RING_STUB_CNT_EN
        // 6: counters count consumed hits and injected responses, then saturate
        for (int j = 0; j < 3; j++) begin
            req_v = 1'b1;
            req_p = mk(10'h30 + 10'(j), RD, 32'h0200_0200 + 4 * j, 32'h0);
            exp_rsp(mk(10'h30 + 10'(j), RD_RSP, 32'h0200_0200 + 4 * j, 32'hDEAD_BEEF), cyc + PD + 1);
            step();
        end
        req_v = 1'b0;
        repeat (8) step();
        @(negedge clk);
        chk("req_cnt_3", 128'(req_cnt), 128'd3);
        chk("rsp_cnt_3", 128'(rsp_cnt), 128'd3);
        step();
        sb_on = 1'b0;
        req_v = 1'b1;
        req_p = mk(10'h31, WR, 32'h0200_0300, 32'h9);
        repeat (65536) step();
        req_v = 1'b0;
        repeat (8) step();
        sb_on = 1'b1;
        @(negedge clk);
        chk("req_cnt_sat", 128'(req_cnt), 128'hFFFF);
        chk("rsp_cnt_sat", 128'(rsp_cnt), 128'hFFFF);
        step();
`endif

        repeat (10) step();
        chk("req_queue_drained", 128'(q_req.size()), 128'd0);
        chk("rsp_queue_drained", 128'(q_rsp.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_stub_tile.md
# ring_stub_tile

Parametrised ring stop that replaces an absent tile on the LOTR request/response ring. Non-targeted requests and all responses pass through a configurable register pipeline. Requests addressed to the stub's own tile ID are removed from the ring and answered with a generated response. Absent tiles therefore cost a fixed pipeline delay and never leave a requestor waiting forever.

## Interface
Parameters:
- PIPE_DEPTH, default 2: register stages on both channels, in to out; legal range 1..8.
- RSP_FIFO_DEPTH, default 4: pending generated responses; power of two, 2..16.
- STUB_ID, default 8'd2: tile ID answered by the stub.
- DEFAULT_RD_DATA, default 32'hDEAD_BEEF: data returned for reads.

Ports:
- QClk  input  1  the block's single clock.
- RstQnnnH  input  1  reset; asynchronous, active-high.
- RingReqInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  input  1/10/t_opcode/32/32  ring request in.
- RingRspInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  input  1/10/t_opcode/32/32  ring response in.
- RingReqOut{Valid,Requestor,Opcode,Address,Data}Q502H  output  same widths  ring request out, PIPE_DEPTH cycles after the input.
- RingRspOut{Valid,Requestor,Opcode,Address,Data}Q502H  output  same widths  ring response out.
- StubReqCntQnnnH, StubRspCntQnnnH  output  16 each  present only with RING_STUB_CNT_EN.

## Operation
- Target tile of a request is Address[31:24]. A request is "hit" when Valid=1 and Address[31:24]==STUB_ID.
- Hit request with the FIFO not full:
  - the request is consumed, so its slot enters the request pipeline with Valid=0;
  - a response is pushed to the FIFO with Requestor and Address copied from the request;
  - opcode RD gives RD_RSP with Data=DEFAULT_RD_DATA;
  - opcode WR gives WR_RSP with the request Data echoed;
  - any other opcode gives WR_RSP with Data=0.
- Hit request with the FIFO full: the request passes through unchanged and is retried on its next lap.
- Non-hit requests pass through unchanged, with all fields preserved.
- Response injection: when RingRspInValidQ500H=0 and the FIFO is non-empty, the FIFO head is popped into the response pipeline's first stage. Otherwise the incoming response takes the stage.
- Incoming responses are never dropped and never delayed beyond PIPE_DEPTH.
- FIFO "full" is evaluated on the registered occupancy at the start of the cycle. A pop in the same cycle does not free space for a simultaneous hit.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- No FIFO bypass: a generated response cannot be injected in the same cycle as its hit.

## Timing
- Pass-through latency: exactly PIPE_DEPTH cycles on both channels, with the same cycle count for valid and payload.
- Generated response: hit at cycle N, earliest RspOut valid at N+1+PIPE_DEPTH.
- Reset, asynchronous assert: all pipeline Valid bits 0, all payload registers 0, FIFO empty, counters 0. All outputs read 0 during reset.
- Reset mid-operation discards in-flight pipeline contents and pending responses. Traffic resumes on the first edge after deassertion.
- Pointer wrap: FIFO pointers carry one extra bit, so full and empty are unambiguous at RSP_FIFO_DEPTH.

## Configuration
- RING_STUB_CNT_EN defined:
  - StubReqCntQnnnH counts consumed hit requests;
  - StubRspCntQnnnH counts injected generated responses;
  - both are 16-bit saturating at 16'hFFFF and reset to 0.
- Not defined: the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- lotr_pkg holds:
  - t_opcode with RD, WR, RD_RSP, WR_RSP;
  - a t_ring_pkt struct bundling requestor, opcode, address and data;
  - the CORE_ID_MSB=31 and CORE_ID_LSB=24 constants.
- Sub-module ring_stub_rsp_fifo: parametrised synchronous FIFO of t_ring_pkt with push, pop, full, empty and head.
- The top module holds the hit decode, response build, injection mux and pipeline arrays.

## Test plan
- Reset, then a non-hit RD to tile 1 at cycle 0 -> identical packet on RingReqOut at cycle PIPE_DEPTH (2). RingRspOut stays invalid.
- RD to 0x0200_0010 from requestor 10'h3 at cycle 0, response channel idle -> ReqOut slot invalid. RspOut carries RD_RSP, addr 0x0200_0010, data 0xDEADBEEF, requestor 10'h3 at cycle 3.
- WR to 0x0200_0004 with data 0x1234 while RspIn is valid for 3 consecutive cycles -> incoming responses pass in order. The generated WR_RSP with data 0x1234 appears the cycle after the last incoming response exits.
- Five back-to-back hits with RspIn continuously valid (depth 4) -> the first 4 are consumed and the 5th appears unchanged on ReqOut. Once RspIn goes idle, 4 generated responses drain in order.
- Reset asserted with 2 pending responses and a full pipeline -> all outputs 0 immediately. After release, no stale response is emitted.
- With RING_STUB_CNT_EN, 3 hits consumed and injected -> both counters read 3. Forcing 65536 hits leaves them at 16'hFFFF.
